// File: rtl/tri_dispatch.sv
// Round-robin triangle dispatcher to 4 raster units: decision-to-start 1 cycle, peak 1 launch / 2 cycles.
// Backpressure: holds tri_valid/tri_flush (no dequeue/ack) while en=0, no unit is free, or the frame drains.
module tri_dispatch #(
   parameter int NUM_UNITS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 tri_valid,
   input  logic                 tri_flush,
   input  logic [NUM_UNITS-1:0] unit_busy,
   output logic                 tri_dequeue,
   output logic [NUM_UNITS-1:0] unit_start,
   output logic                 flush_ack,
   output logic                 frame_done,
   output logic [CNT_W-1:0]     tri_count,
   output logic [CNT_W-1:0]     frame_tris,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               r_state;
   logic [1:0]           r_rr_ptr;
   logic [NUM_UNITS-1:0] r_pending;

   logic [NUM_UNITS-1:0] w_free;
   logic [NUM_UNITS-1:0] w_sel_oh;
   logic [1:0]           w_sel;
   logic [1:0]           w_idx;
   logic                 w_any_free;
   logic                 w_launch;
   logic                 w_stall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Scan from the highest offset down so the last hit is the first free unit at/after rr_ptr.
   always_comb begin
      w_free     = ~unit_busy & ~r_pending;
      w_any_free = |w_free;
      w_sel      = r_rr_ptr;
      w_idx      = r_rr_ptr;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         w_idx = r_rr_ptr + 2'(i);
         if (w_free[w_idx]) begin
            w_sel = w_idx;
         end
      end
      w_sel_oh = NUM_UNITS'(1) << w_sel;
      w_launch = en & tri_valid & w_any_free;
      w_stall  = en & tri_valid & ~w_any_free;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_rr_ptr     <= 2'd0;
         r_pending    <= '0;
         tri_dequeue  <= 1'b0;
         unit_start   <= '0;
         flush_ack    <= 1'b0;
         frame_done   <= 1'b0;
         tri_count    <= '0;
         frame_tris   <= '0;
         stall_cycles <= '0;
      end else begin
         tri_dequeue <= 1'b0;
         unit_start  <= '0;
         flush_ack   <= 1'b0;
         frame_done  <= 1'b0;
         r_pending   <= '0;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  unit_start  <= w_sel_oh;
                  r_pending   <= w_sel_oh;
                  tri_dequeue <= 1'b1;
                  r_rr_ptr    <= w_sel + 2'd1;
                  tri_count   <= sat_inc(tri_count);
                  r_state     <= LAUNCH;
               end else if (!tri_valid && tri_flush) begin
                  r_state <= DRAIN;
               end
               if (w_stall) begin
                  stall_cycles <= sat_inc(stall_cycles);
               end
            end
            LAUNCH: begin
               r_state <= IDLE;
            end
            // Pulses are registered on entry so they coincide with the DONE cycle.
            DRAIN: begin
               if (unit_busy == '0 && r_pending == '0) begin
                  frame_done <= 1'b1;
                  flush_ack  <= 1'b1;
                  frame_tris <= tri_count;
                  tri_count  <= '0;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign state_dbg = r_state;

endmodule

// File: tb/tb_tri_dispatch.sv
// Directed bench for tri_dispatch; counters narrowed to 4 bits so saturation is reachable.
module tb_tri_dispatch;

   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          en;
   logic          tri_valid;
   logic          tri_flush;
   logic [3:0]    unit_busy;
   logic          tri_dequeue;
   logic [3:0]    unit_start;
   logic          flush_ack;
   logic          frame_done;
   logic [CW-1:0] tri_count;
   logic [CW-1:0] frame_tris;
   logic [CW-1:0] stall_cycles;
   logic [1:0]    state_dbg;

   int n_checks;
   int n_pass;
   int n_fail;

   tri_dispatch #(.NUM_UNITS(4), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .tri_valid    (tri_valid),
      .tri_flush    (tri_flush),
      .unit_busy    (unit_busy),
      .tri_dequeue  (tri_dequeue),
      .unit_start   (unit_start),
      .flush_ack    (flush_ack),
      .frame_done   (frame_done),
      .tri_count    (tri_count),
      .frame_tris   (frame_tris),
      .stall_cycles (stall_cycles),
      .state_dbg    (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are observed 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] exp_oh [3];

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      reset     = 1'b1;
      en        = 1'b1;
      tri_valid = 1'b0;
      tri_flush = 1'b0;
      unit_busy = 4'b0000;
      step();
      step();
      chk("rst_state", 32'(state_dbg), 32'd0);
      chk("rst_start", 32'(unit_start), 32'd0);
      chk("rst_deq", 32'(tri_dequeue), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_ack", 32'(flush_ack), 32'd0);
      chk("rst_count", 32'(tri_count), 32'd0);
      chk("rst_ftris", 32'(frame_tris), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      reset = 1'b0;

      // Round-robin, no units busy: 8 launches two cycles apart.
      tri_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_start", 32'(unit_start), 32'(4'b0001 << (i % 4)));
         chk("rr_deq", 32'(tri_dequeue), 32'd1);
         chk("rr_state", 32'(state_dbg), 32'd1);
         step();
         chk("rr_gap", 32'(unit_start), 32'd0);
      end
      chk("rr_count", 32'(tri_count), 32'd8);

      // Move rr_ptr to 1, then skip busy units 1 and 2.
      step();
      chk("skip_pre", 32'(unit_start), 32'b0001);
      step();
      unit_busy = 4'b0110;
      step();
      chk("skip_sel3", 32'(unit_start), 32'b1000);
      step();
      step();
      chk("skip_wrap0", 32'(unit_start), 32'b0001);
      step();
      tri_valid = 1'b0;
      unit_busy = 4'b0000;
      chk("skip_count", 32'(tri_count), 32'd11);

      // Immediate flush with all units idle closes the frame.
      tri_flush = 1'b1;
      step();
      chk("fl0_drain", 32'(state_dbg), 32'd2);
      step();
      chk("fl0_done", 32'(frame_done), 32'd1);
      chk("fl0_ack", 32'(flush_ack), 32'd1);
      chk("fl0_ftris", 32'(frame_tris), 32'd11);
      chk("fl0_count", 32'(tri_count), 32'd0);
      chk("fl0_state", 32'(state_dbg), 32'd3);
      tri_flush = 1'b0;
      step();
      chk("fl0_pulse", 32'(frame_done), 32'd0);

      // All busy for 10 cycles, then release unit 2.
      unit_busy = 4'b1111;
      tri_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("busy_nostart", 32'(unit_start), 32'd0);
      end
      chk("busy_stall", 32'(stall_cycles), 32'd10);
      unit_busy = 4'b1011;
      step();
      chk("busy_rel2", 32'(unit_start), 32'b0100);
      chk("busy_stall_hold", 32'(stall_cycles), 32'd10);
      step();
      tri_valid = 1'b0;
      unit_busy = 4'b0000;

      // Close that one-triangle frame.
      tri_flush = 1'b1;
      step();
      step();
      chk("fl1_ftris", 32'(frame_tris), 32'd1);
      tri_flush = 1'b0;
      step();

      // Three launches, then flush while units 0 and 1 are still busy.
      exp_oh[0] = 4'b1000;
      exp_oh[1] = 4'b0001;
      exp_oh[2] = 4'b0010;
      tri_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl2_launch", 32'(unit_start), 32'(exp_oh[i]));
         step();
      end
      tri_valid = 1'b0;
      unit_busy = 4'b0011;
      tri_flush = 1'b1;
      step();
      chk("fl2_drain", 32'(state_dbg), 32'd2);
      tri_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl2_hold", 32'(state_dbg), 32'd2);
         chk("fl2_nostart", 32'(unit_start), 32'd0);
         chk("fl2_nodone", 32'(frame_done), 32'd0);
      end
      tri_valid = 1'b0;
      unit_busy = 4'b0000;
      step();
      chk("fl2_done", 32'(frame_done), 32'd1);
      chk("fl2_ack", 32'(flush_ack), 32'd1);
      chk("fl2_ftris", 32'(frame_tris), 32'd3);
      chk("fl2_count", 32'(tri_count), 32'd0);
      tri_flush = 1'b0;
      step();
      chk("fl2_idle", 32'(state_dbg), 32'd0);
      chk("fl2_pulse", 32'(flush_ack), 32'd0);

      // Valid wins over flush.
      tri_valid = 1'b1;
      tri_flush = 1'b1;
      step();
      chk("prio_start", 32'(unit_start), 32'b0100);
      chk("prio_state", 32'(state_dbg), 32'd1);
      tri_valid = 1'b0;
      tri_flush = 1'b0;
      step();
      chk("prio_idle", 32'(state_dbg), 32'd0);

      // en=0 blocks launches and is not a stall.
      en        = 1'b0;
      tri_valid = 1'b1;
      unit_busy = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) unit_busy = 4'b0000;
         step();
         chk("en0_nostart", 32'(unit_start), 32'd0);
      end
      chk("en0_stall", 32'(stall_cycles), 32'd10);

      // Stall counter saturates.
      en        = 1'b1;
      unit_busy = 4'b1111;
      for (int i = 0; i < 8; i++) step();
      chk("stall_sat", 32'(stall_cycles), 32'd15);

      // Triangle counter saturates.
      unit_busy = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         step();
         step();
      end
      tri_valid = 1'b0;
      chk("count_sat", 32'(tri_count), 32'd15);

      // Reset in the middle of a drain.
      unit_busy = 4'b0001;
      tri_flush = 1'b1;
      step();
      chk("rd_drain", 32'(state_dbg), 32'd2);
      step();
      reset = 1'b1;
      step();
      chk("rd_state", 32'(state_dbg), 32'd0);
      chk("rd_done", 32'(frame_done), 32'd0);
      chk("rd_count", 32'(tri_count), 32'd0);
      chk("rd_ftris", 32'(frame_tris), 32'd0);
      chk("rd_stall", 32'(stall_cycles), 32'd0);
      reset     = 1'b0;
      unit_busy = 4'b0000;
      tri_flush = 1'b0;
      step();
      chk("rd_after", 32'(frame_done), 32'd0);

      // Reset on the edge that would launch suppresses the pulse; rr_ptr restarts at 0.
      tri_valid = 1'b1;
      reset     = 1'b1;
      step();
      chk("rl_start", 32'(unit_start), 32'd0);
      chk("rl_deq", 32'(tri_dequeue), 32'd0);
      reset = 1'b0;
      step();
      chk("rl_ptr0", 32'(unit_start), 32'b0001);
      tri_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tri_dispatch.md
TRI_DISPATCH -- requirements
Module: tri_dispatch

Interface
REQ-001 Parameters (name, default, meaning): NUM_UNITS, 4, rasterizer units served (fixed; no other value supported). CNT_W, 16, width of triangle and stall counters.
REQ-002 Clocking and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-003 Ports SHALL be exactly, in this order (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  launch enable; 0 blocks new launches, draining continues
- tri_valid  in  1  assembled triangle present; held high until consumed
- tri_flush  in  1  end-of-frame marker present; held high until acknowledged
- unit_busy  in  4  per-unit busy; rises 1 cycle after that unit's start, falls when the unit finishes
- tri_dequeue  out  1  one-cycle pulse, consumes the current triangle
- unit_start  out  4  one-hot pulse; selected unit captures the triangle bus this cycle
- flush_ack  out  1  one-cycle pulse, consumes the flush marker
- frame_done  out  1  one-cycle pulse, frame fully rasterized
- tri_count  out  CNT_W  triangles launched in the current frame, saturating
- frame_tris  out  CNT_W  tri_count value latched at the last frame_done
- stall_cycles  out  CNT_W  cycles with tri_valid=1 and no unit free, saturating
- state_dbg  out  2  current FSM state encoding

Function
REQ-004 All outputs SHALL be registered.
REQ-005 FSM states SHALL be IDLE=0, LAUNCH=1, DRAIN=2, DONE=3.
REQ-006 Unit k SHALL be free when unit_busy[k]=0 and pending[k]=0, where pending[k] is set on the cycle unit_start[k] is driven and cleared one cycle later.
REQ-007 IDLE: if en=1, tri_valid=1, and at least one unit is free, the block SHALL select a unit as defined in REQ-008. On the next edge it SHALL drive unit_start[sel]=1 and tri_dequeue=1 for exactly one cycle and enter LAUNCH.
REQ-008 Selection SHALL be round-robin: the first free unit at or after rr_ptr, wrapping 3->0. After each launch, rr_ptr SHALL become (sel+1) mod 4.
REQ-009 LAUNCH SHALL last exactly one cycle, with no start, and then return to IDLE. Peak launch rate is therefore one triangle per 2 cycles.
REQ-010 IDLE: if tri_valid=0 and tri_flush=1, the block SHALL enter DRAIN. If tri_valid and tri_flush are both 1, tri_valid SHALL take priority.
REQ-011 DRAIN: the block SHALL launch nothing and SHALL remain in DRAIN until unit_busy=0 and pending=0 for the sampled cycle, then enter DONE.
REQ-012 DONE: the block SHALL pulse frame_done=1 and flush_ack=1 for one cycle. It SHALL latch frame_tris<=tri_count and clear tri_count, leave rr_ptr unchanged, and return to IDLE.
REQ-013 tri_count SHALL increment on each unit_start pulse and SHALL saturate at all-ones.
REQ-014 stall_cycles SHALL increment in IDLE when en=1, tri_valid=1, and no unit is free. It SHALL saturate at all-ones, SHALL NOT clear on frame_done, and SHALL clear only on reset.
REQ-015 The en=0 condition SHALL NOT count as a stall.
REQ-016 unit_start SHALL never be multi-hot. It SHALL never target a unit that is busy or pending.
REQ-017 tri_dequeue SHALL coincide exactly with unit_start being nonzero.
REQ-018 unit_busy rising on a unit with no preceding start SHALL be tolerated, treating that unit as not free, with no error output.

Reset
REQ-019 On reset=1 at a clock edge the block SHALL set: state=IDLE, rr_ptr=0, pending=0, tri_dequeue=0, unit_start=0, flush_ack=0, frame_done=0, tri_count=0, frame_tris=0, stall_cycles=0.
REQ-020 Reset asserted in any state, including mid-DRAIN or LAUNCH, SHALL abort without issuing further pulses. Any pulse already registered SHALL be cleared on the reset edge.

Verification
REQ-021 Round-robin: unit_busy=0, tri_valid held 1 for 8 launches -> unit_start sequence 0001,0010,0100,1000,0001,... spaced 2 cycles apart; tri_count=8.
REQ-022 Skip busy: unit_busy=0110, rr_ptr=1, tri_valid=1 -> unit_start=1000, then rr_ptr=0, next launch unit_start=0001.
REQ-023 All busy: unit_busy=1111, tri_valid=1 for 10 cycles -> no start, stall_cycles=10. Release unit 2 -> unit_start=0100 on the following edge.
REQ-024 Flush drain: 3 launches, then tri_flush=1 while unit_busy=0011 -> stays in DRAIN. Busy clears -> one cycle later frame_done=flush_ack=1, frame_tris=3, tri_count=0.
REQ-025 Priority and enable: tri_valid=tri_flush=1 -> launch first. en=0 with tri_valid=1 -> no start and stall_cycles unchanged.
REQ-026 Reset mid-DRAIN: reset=1 for 1 cycle -> state_dbg=0, no frame_done, all counters 0.
